rps_round_ctrl: RTL and testbench
=================================

Name: rps_round_ctrl

Overview:
- Round sequencer for the rock-paper-scissors game.
- On a play request it latches the user's move, requests a move from the selected computer strategy engine (random / markov / reinforce), and judges the round.
- It then updates the saturating scores, feeds the outcome back to the learning engines, and triggers the VGA draw of both hands.
- Sits between the board switches/keys and the strategy engines, score HEX decoders and drawing units.

Parameters:
- ACK_TIMEOUT, 16, cycles to wait in REQ for the engine ack before falling back to the random engine's choice.
- SCORE_W, 8, score counter width.

Ports:
- CLOCK_50  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- play  in  1  level request (switch); a round starts on its rising edge
- user_choice  in  2  00 rock, 01 scissor, 10 paper, 11 invalid
- mode  in  2  engine select: 00 random, 01 markov, 10 reinforce, 11 treated as 00
- eng_req  out  3  one-hot request to the selected engine
- eng_ack  in  3  per-engine ack
- eng_choice0, eng_choice1, eng_choice2  in  2 each  engine moves; engine 0 (random) is always valid
- upd_valid  out  1  one-cycle outcome broadcast to engines
- combination  out  4  {user, com} of the judged round
- reward  out  2  two's complement from the computer's view: +1 computer win, 0 draw, -1 computer loss
- draw_req  out  1  draw both hands; held until draw_done
- draw_done  in  1  drawing units finished
- last_user, last_com  out  2 each  moves of the last judged round
- user_score, com_score  out  SCORE_W  scores
- uwin, cwin, equ  out  1 each  last-round result flags (one-hot or all zero)
- busy  out  1  high in every state except IDLE
- err_invalid  out  1  sticky: play attempted with user_choice=11
- timeout_flag  out  1  last round used the fallback move

Behaviour:
- Reset (reset_n=0 at a clock edge): state IDLE; all outputs 0; play edge register cleared. Applies in any state and aborts the round; scores go to 0.
- play_q registers play. Rising edge = play & ~play_q, evaluated in IDLE only.
- IDLE:
  - Edge with user_choice=11: set err_invalid and stay in IDLE.
  - Edge with valid choice: latch user_choice and mode, clear err_invalid, clear timeout_flag, clear the timeout counter, go to REQ.
- REQ:
  - eng_req[sel]=1 every REQ cycle, other bits 0.
  - eng_ack[sel]=1: latch eng_choice[sel] into the com register (value 11 replaced by 00), go to JUDGE.
  - Counter reaches ACK_TIMEOUT with no ack: latch eng_choice0, set timeout_flag, go to JUDGE.
  - Ack in the same cycle as expiry: the ack wins.
  - Acks from unselected engines are ignored.
- JUDGE (one cycle):
  - Rock beats scissor, scissor beats paper, paper beats rock; equal moves draw.
  - Register last_user/last_com and exactly one of uwin/cwin/equ.
  - Increment the winner's score, saturating at 2^SCORE_W-1; a draw changes neither score.
- UPDATE (one cycle): upd_valid=1 with combination and reward valid in the same cycle; go to DRAW.
- DRAW: draw_req=1 until draw_done=1, then go to HOLD. A draw_done already high on entry completes in one cycle.
- HOLD: stay until play=0, then go to IDLE. This prevents a held switch from replaying.
- Latency: from the play edge to the result flags is 3 cycles plus the ack wait (minimum 3 with a same-cycle ack).
- Result flags, last moves and scores hold until the next JUDGE or reset.
- Inputs user_choice and mode are ignored outside IDLE.

Decomposition:
- Package rps_pkg holds:
  - choice encodings ROCK=2'b00, SCISSOR=2'b01, PAPER=2'b10
  - outcome enum {DRAW, UWIN, CWIN}
  - the state enum {IDLE, REQ, JUDGE, UPDATE, DRAW, HOLD}
  - reward constants.
- Sub-module rps_judge: combinational (user, com) -> outcome. It is shared with the engines' own reward logic.

Test Plan:
- Reset, mode=00, user=00, play 0->1, engine 0 acks with 01 on the first REQ cycle -> uwin=1, user_score=1, reward=2'b11, combination=4'b0001, draw_req until draw_done.
- mode=01, user=10, engine 1 acks after 5 cycles with 01 -> eng_req=3'b010 for 6 cycles, cwin=1, com_score=1, reward=2'b01.
- mode=10, engine 2 never acks, eng_choice0=10, user=10 -> after ACK_TIMEOUT cycles timeout_flag=1, equ=1, scores unchanged.
- user_choice=11, play edge -> err_invalid=1, state stays IDLE, eng_req=0. Next valid round clears err_invalid.
- Preload user_score=255 via 255 wins -> the next user win keeps 255. Play held high after the round -> no second round until play falls and rises again.
- reset_n=0 during DRAW -> next cycle draw_req=0, busy=0, scores=0, flags=0.

Source files
------------

// File: rtl/rps_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rps_pkg
// Brief    : Shared encodings for the rock-paper-scissors round logic.
// Revision : 1.0 - initial release
// ============================================================================
package rps_pkg;

    localparam logic [1:0] c_ROCK    = 2'b00;
    localparam logic [1:0] c_SCISSOR = 2'b01;
    localparam logic [1:0] c_PAPER   = 2'b10;
    localparam logic [1:0] c_INVALID = 2'b11;

    // Rewards are seen from the computer's side, two's complement.
    localparam logic [1:0] c_REWARD_WIN  = 2'b01;
    localparam logic [1:0] c_REWARD_DRAW = 2'b00;
    localparam logic [1:0] c_REWARD_LOSS = 2'b11;

    typedef enum logic [1:0] {
        OUT_DRAW = 2'd0,
        OUT_UWIN = 2'd1,
        OUT_CWIN = 2'd2
    } outcome_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_JUDGE  = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DRAW   = 3'd4,
        ST_HOLD   = 3'd5
    } state_t;

    function automatic logic [1:0] sanitize_choice(input logic [1:0] c);
        return (c == c_INVALID) ? c_ROCK : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rps_round_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rps_round_ctrl_if
// Brief    : Engine request/ack, outcome broadcast and draw handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface rps_round_ctrl_if;

    logic [2:0] eng_req;
    logic [2:0] eng_ack;
    logic [1:0] eng_choice0;
    logic [1:0] eng_choice1;
    logic [1:0] eng_choice2;
    logic       upd_valid;
    logic [3:0] combination;
    logic [1:0] reward;
    logic       draw_req;
    logic       draw_done;

    modport master (
        output eng_req, upd_valid, combination, reward, draw_req,
        input  eng_ack, eng_choice0, eng_choice1, eng_choice2, draw_done
    );

    modport slave (
        input  eng_req, upd_valid, combination, reward, draw_req,
        output eng_ack, eng_choice0, eng_choice1, eng_choice2, draw_done
    );

endinterface
`default_nettype wire

// File: rtl/rps_judge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rps_judge
// Brief    : Combinational round judge, (user, com) -> outcome.
// Revision : 1.0 - initial release
// ============================================================================
module rps_judge
    import rps_pkg::*;
(
    input  logic [1:0] user,
    input  logic [1:0] com,
    output outcome_t   outcome
);

    logic w_user_beats;

    assign w_user_beats = ((user == c_ROCK)    && (com == c_SCISSOR)) ||
                          ((user == c_SCISSOR) && (com == c_PAPER))   ||
                          ((user == c_PAPER)   && (com == c_ROCK));

    always_comb begin
        outcome = OUT_DRAW;
        if (user != com) begin
            outcome = w_user_beats ? OUT_UWIN : OUT_CWIN;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rps_round_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rps_round_ctrl
// Brief    : Round sequencer: latch move, query engine, judge, score, draw.
// Revision : 1.0 - initial release
// ============================================================================
module rps_round_ctrl
    import rps_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int SCORE_W     = 8
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    input  logic               play,
    input  logic [1:0]         user_choice,
    input  logic [1:0]         mode,
    rps_round_ctrl_if.master   bus,
    output logic [1:0]         last_user,
    output logic [1:0]         last_com,
    output logic [SCORE_W-1:0] user_score,
    output logic [SCORE_W-1:0] com_score,
    output logic               uwin,
    output logic               cwin,
    output logic               equ,
    output logic               busy,
    output logic               err_invalid,
    output logic               timeout_flag
);

    localparam int c_CNT_W = $clog2(ACK_TIMEOUT + 1);

    state_t               r_state, w_next;
    logic                 r_play_q;
    logic [1:0]           r_user, r_com, r_sel;
    logic [1:0]           r_last_user, r_last_com;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [SCORE_W-1:0]   r_uscore, r_cscore;
    logic                 r_uwin, r_cwin, r_equ, r_err, r_to;
    logic                 w_edge, w_ack_sel, w_timeout;
    logic [2:0]           w_sel_oh;
    logic [1:0]           w_choice_sel;
    outcome_t             w_outcome;

    assign w_edge    = play & ~r_play_q;
    assign w_sel_oh  = 3'b001 << r_sel;
    assign w_ack_sel = |(bus.eng_ack & w_sel_oh);
    assign w_timeout = (r_cnt == c_CNT_W'(ACK_TIMEOUT - 1));

    always_comb begin
        case (r_sel)
            2'd1:    w_choice_sel = bus.eng_choice1;
            2'd2:    w_choice_sel = bus.eng_choice2;
            default: w_choice_sel = bus.eng_choice0;
        endcase
    end

    rps_judge u_judge (
        .user    (r_user),
        .com     (r_com),
        .outcome (w_outcome)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_edge && (user_choice != c_INVALID)) w_next = ST_REQ;
            ST_REQ:    if (w_ack_sel || w_timeout)               w_next = ST_JUDGE;
            ST_JUDGE:  w_next = ST_UPDATE;
            ST_UPDATE: w_next = ST_DRAW;
            ST_DRAW:   if (bus.draw_done)                        w_next = ST_HOLD;
            ST_HOLD:   if (!play)                                w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.eng_req     = (r_state == ST_REQ) ? w_sel_oh : 3'b000;
        bus.upd_valid   = (r_state == ST_UPDATE);
        bus.draw_req    = (r_state == ST_DRAW);
        bus.combination = {r_last_user, r_last_com};
        bus.reward      = c_REWARD_DRAW;
        if (r_cwin) bus.reward = c_REWARD_WIN;
        if (r_uwin) bus.reward = c_REWARD_LOSS;
        busy            = (r_state != ST_IDLE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_play_q    <= 1'b0;
            r_user      <= 2'b00;
            r_com       <= 2'b00;
            r_sel       <= 2'b00;
            r_cnt       <= '0;
            r_last_user <= 2'b00;
            r_last_com  <= 2'b00;
            r_uscore    <= '0;
            r_cscore    <= '0;
            r_uwin      <= 1'b0;
            r_cwin      <= 1'b0;
            r_equ       <= 1'b0;
            r_err       <= 1'b0;
            r_to        <= 1'b0;
        end else begin
            r_play_q <= play;
            case (r_state)
                ST_IDLE: begin
                    if (w_edge) begin
                        if (user_choice == c_INVALID) begin
                            r_err <= 1'b1;
                        end else begin
                            r_user <= user_choice;
                            r_sel  <= (mode == 2'b11) ? 2'b00 : mode;
                            r_err  <= 1'b0;
                            r_to   <= 1'b0;
                            r_cnt  <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    // A late ack still beats the fallback in the expiry cycle.
                    if (w_ack_sel) begin
                        r_com <= sanitize_choice(w_choice_sel);
                    end else if (w_timeout) begin
                        r_com <= sanitize_choice(bus.eng_choice0);
                        r_to  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_JUDGE: begin
                    r_last_user <= r_user;
                    r_last_com  <= r_com;
                    r_uwin      <= (w_outcome == OUT_UWIN);
                    r_cwin      <= (w_outcome == OUT_CWIN);
                    r_equ       <= (w_outcome == OUT_DRAW);
                    if ((w_outcome == OUT_UWIN) && (r_uscore != '1)) r_uscore <= r_uscore + 1'b1;
                    if ((w_outcome == OUT_CWIN) && (r_cscore != '1)) r_cscore <= r_cscore + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign last_user    = r_last_user;
    assign last_com     = r_last_com;
    assign user_score   = r_uscore;
    assign com_score    = r_cscore;
    assign uwin         = r_uwin;
    assign cwin         = r_cwin;
    assign equ          = r_equ;
    assign err_invalid  = r_err;
    assign timeout_flag = r_to;

endmodule
`default_nettype wire

// File: tb/tb_rps_round_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rps_round_ctrl
// Brief    : Directed self-checking bench for the round sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rps_round_ctrl;

    logic       CLOCK_50;
    logic       reset_n;
    logic       play;
    logic [1:0] user_choice;
    logic [1:0] mode;
    logic [1:0] last_user, last_com;
    logic [7:0] user_score, com_score;
    logic       uwin, cwin, equ, busy, err_invalid, timeout_flag;

    int err_cnt = 0;
    int chk_cnt = 0;
    int exp_us  = 0;
    int exp_cs  = 0;

    rps_round_ctrl_if bus ();

    rps_round_ctrl #(.ACK_TIMEOUT(16), .SCORE_W(8)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset_n      (reset_n),
        .play         (play),
        .user_choice  (user_choice),
        .mode         (mode),
        .bus          (bus),
        .last_user    (last_user),
        .last_com     (last_com),
        .user_score   (user_score),
        .com_score    (com_score),
        .uwin         (uwin),
        .cwin         (cwin),
        .equ          (equ),
        .busy         (busy),
        .err_invalid  (err_invalid),
        .timeout_flag (timeout_flag)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_scores();
        check_val("user_score", 32'(user_score), 32'(exp_us));
        check_val("com_score",  32'(com_score),  32'(exp_cs));
    endtask

    // Unselected engines ack every REQ cycle; only the selected ack may count.
    task automatic run_round(input logic [1:0] u, input logic [1:0] m, input int ack_after,
                             input int draw_wait, input int hold_n, input logic [3:0] exp_combo,
                             input logic [2:0] exp_res, input logic [1:0] exp_rew,
                             input logic exp_to, input int exp_nreq);
        logic [1:0] sel;
        logic [2:0] oh;
        int         n_req, n_draw;
        sel = (m == 2'b11) ? 2'b00 : m;
        oh  = 3'b001 << sel;
        @(negedge CLOCK_50);
        user_choice = u;
        mode        = m;
        play        = 1'b1;
        n_req = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge CLOCK_50);
            if (bus.eng_req == 3'b000) break;
            if (k == 0) check_val("eng_req_onehot", 32'(bus.eng_req), 32'(oh));
            n_req++;
            user_choice = ~u;
            mode        = ~m;
            bus.eng_ack = (k == ack_after) ? 3'b111 : ~oh;
        end
        bus.eng_ack = 3'b000;
        check_val("req_cycles", 32'(n_req), 32'(exp_nreq));
        @(negedge CLOCK_50);
        check_val("upd_valid",   32'(bus.upd_valid),   32'd1);
        check_val("combination", 32'(bus.combination), 32'(exp_combo));
        check_val("reward",      32'(bus.reward),      32'(exp_rew));
        check_val("result_flags", 32'({uwin, cwin, equ}), 32'(exp_res));
        check_val("timeout_flag", 32'(timeout_flag),   32'(exp_to));
        bus.draw_done = (draw_wait == 0);
        n_draw = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge CLOCK_50);
            if (!bus.draw_req) break;
            n_draw++;
            if (k + 1 >= draw_wait) bus.draw_done = 1'b1;
        end
        bus.draw_done = 1'b0;
        check_val("draw_cycles", 32'(n_draw), 32'((draw_wait == 0) ? 1 : draw_wait));
        for (int k = 0; k < hold_n; k++) begin
            check_val("hold_no_replay", 32'({busy, bus.eng_req}), 32'h8);
            @(negedge CLOCK_50);
        end
        play = 1'b0;
        @(negedge CLOCK_50);
        check_val("idle_after_hold", 32'(busy), 32'd0);
    endtask

    initial begin
        reset_n         = 1'b0;
        play            = 1'b0;
        user_choice     = 2'b00;
        mode            = 2'b00;
        bus.eng_ack     = 3'b000;
        bus.eng_choice0 = 2'b00;
        bus.eng_choice1 = 2'b00;
        bus.eng_choice2 = 2'b00;
        bus.draw_done   = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check_val("reset_outputs",
                  32'({bus.eng_req, bus.upd_valid, bus.draw_req, busy, uwin, cwin, equ,
                       err_invalid, timeout_flag, last_user, last_com}), 32'd0);
        check_scores();
        reset_n = 1'b1;

        // Rock vs scissor, immediate ack, draw unit takes 2 cycles.
        bus.eng_choice0 = 2'b01;
        run_round(2'b00, 2'b00, 0, 2, 1, 4'b0001, 3'b100, 2'b11, 1'b0, 1);
        exp_us = 1;
        check_scores();
        check_val("last_moves", 32'({last_user, last_com}), 32'h1);

        // Paper vs scissor from markov after a 5-cycle wait.
        bus.eng_choice1 = 2'b01;
        run_round(2'b10, 2'b01, 5, 0, 0, 4'b1001, 3'b010, 2'b01, 1'b0, 6);
        exp_cs = 1;
        check_scores();

        // Reinforce never acks: fallback to random engine's paper.
        bus.eng_choice0 = 2'b10;
        bus.eng_choice2 = 2'b00;
        run_round(2'b10, 2'b10, -1, 0, 0, 4'b1010, 3'b001, 2'b00, 1'b1, 16);
        check_scores();

        // Invalid user move leaves the sequencer idle.
        @(negedge CLOCK_50);
        user_choice = 2'b11;
        play        = 1'b1;
        @(negedge CLOCK_50);
        check_val("invalid_err", 32'(err_invalid), 32'd1);
        check_val("invalid_idle", 32'({busy, bus.eng_req}), 32'd0);
        play = 1'b0;
        @(negedge CLOCK_50);
        check_val("invalid_sticky", 32'(err_invalid), 32'd1);

        // Mode 11 maps to random; scissor vs rock.
        bus.eng_choice0 = 2'b00;
        run_round(2'b01, 2'b11, 0, 0, 0, 4'b0100, 3'b010, 2'b01, 1'b0, 1);
        exp_cs = 2;
        check_scores();
        check_val("err_cleared", 32'(err_invalid), 32'd0);

        // Ack arrives in the expiry cycle and must win over the fallback.
        bus.eng_choice1 = 2'b10;
        bus.eng_choice0 = 2'b01;
        run_round(2'b00, 2'b01, 15, 0, 0, 4'b0010, 3'b010, 2'b01, 1'b0, 16);
        exp_cs = 3;
        check_scores();

        // Engine reports 11, which is taken as rock.
        bus.eng_choice2 = 2'b11;
        run_round(2'b10, 2'b10, 0, 0, 0, 4'b1000, 3'b100, 2'b11, 1'b0, 1);
        exp_us = 2;
        check_scores();

        // Drive the user score to saturation.
        bus.eng_choice0 = 2'b01;
        while (exp_us < 255) begin
            run_round(2'b00, 2'b00, 0, 0, 0, 4'b0001, 3'b100, 2'b11, 1'b0, 1);
            exp_us++;
        end
        check_scores();
        run_round(2'b00, 2'b00, 0, 0, 5, 4'b0001, 3'b100, 2'b11, 1'b0, 1);
        check_scores();

        // Reset in the middle of DRAW aborts the round.
        @(negedge CLOCK_50);
        user_choice = 2'b00;
        mode        = 2'b00;
        play        = 1'b1;
        @(negedge CLOCK_50);
        bus.eng_ack = 3'b001;
        @(negedge CLOCK_50);
        bus.eng_ack = 3'b000;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        check_val("in_draw", 32'(bus.draw_req), 32'd1);
        reset_n = 1'b0;
        @(negedge CLOCK_50);
        exp_us = 0;
        exp_cs = 0;
        check_val("abort_outputs",
                  32'({bus.draw_req, busy, uwin, cwin, equ, err_invalid, timeout_flag}), 32'd0);
        check_scores();
        reset_n = 1'b1;
        play    = 1'b0;
        repeat (2) @(negedge CLOCK_50);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
